// File: rtl/datamem_arbiter.sv
// ============================================================================
// Module   : datamem_arbiter
// Purpose  : Round-robin two-port arbiter and strobe sequencer for the
//            single-port data memory, with out-of-range address rejection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module datamem_arbiter #(
    parameter int DEPTH   = 65,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AReq,
    input  logic        BReq,
    input  logic        AWrite,
    input  logic        BWrite,
    input  logic [31:0] AAddress,
    input  logic [31:0] BAddress,
    input  logic [31:0] AWritedata,
    input  logic [31:0] BWritedata,
    output logic        AAck,
    output logic        BAck,
    output logic        AErr,
    output logic        BErr,
    output logic [31:0] AReaddata,
    output logic [31:0] BReaddata,
    output logic [31:0] Address,
    output logic [31:0] Writedata,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Readdata,
    output logic        Busy
);

    localparam logic [31:0] c_depth    = 32'(DEPTH);
    localparam logic [3:0]  c_lat_init = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_b;
    logic        r_gnt_b;
    logic        r_write;
    logic        r_err;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;

    logic        w_grant;
    logic        w_sel_b;
    logic        w_req_write;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic        w_oor;

    // B wins only when it is alone or A was served last.
    always_comb begin
        w_grant     = AReq | BReq;
        w_sel_b     = BReq & (~AReq | ~r_last_b);
        w_req_write = w_sel_b ? BWrite     : AWrite;
        w_req_addr  = w_sel_b ? BAddress   : AAddress;
        w_req_wdata = w_sel_b ? BWritedata : AWritedata;
        w_oor       = (w_req_addr >= c_depth);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = w_oor ? S_DONE : S_SERVE;
                end
            end
            S_SERVE: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Rejected accesses leave the memory-side address/data untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_b  <= 1'b1;
            r_gnt_b   <= 1'b0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_a_rdata <= 32'd0;
            r_b_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt_b  <= w_sel_b;
                        r_last_b <= w_sel_b;
                        r_write  <= w_req_write;
                        r_err    <= w_oor;
                        r_cnt    <= c_lat_init;
                        if (!w_oor) begin
                            r_addr  <= w_req_addr;
                            r_wdata <= w_req_wdata;
                        end
                    end
                end
                S_SERVE: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_write) begin
                            if (r_gnt_b) begin
                                r_b_rdata <= Readdata;
                            end else begin
                                r_a_rdata <= Readdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MemRead   = (r_state == S_SERVE) & ~r_write;
    assign MemWrite  = (r_state == S_SERVE) &  r_write;
    assign AAck      = (r_state == S_DONE)  & ~r_gnt_b;
    assign BAck      = (r_state == S_DONE)  &  r_gnt_b;
    assign AErr      = AAck & r_err;
    assign BErr      = BAck & r_err;
    assign Busy      = (r_state != S_IDLE);
    assign Address   = r_addr;
    assign Writedata = r_wdata;
    assign AReaddata = r_a_rdata;
    assign BReaddata = r_b_rdata;

endmodule

`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
// ============================================================================
// Module   : tb_datamem_arbiter
// Purpose  : Directed self-checking bench for datamem_arbiter (MEM_LAT 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datamem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic        areq1, breq1, awrite1, bwrite1;
    logic [31:0] aaddr1, baddr1, awdata1, bwdata1;
    logic        aack1, back1, aerr1, berr1, memread1, memwrite1, busy1;
    logic [31:0] ardata1, brdata1, address1, writedata1, readdata1;

    logic        areq3, breq3, awrite3, bwrite3;
    logic [31:0] aaddr3, baddr3, awdata3, bwdata3;
    logic        aack3, back3, aerr3, berr3, memread3, memwrite3, busy3;
    logic [31:0] ardata3, brdata3, address3, writedata3, readdata3;

    datamem_arbiter #(.DEPTH(65), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .AReq(areq1), .BReq(breq1), .AWrite(awrite1), .BWrite(bwrite1),
        .AAddress(aaddr1), .BAddress(baddr1),
        .AWritedata(awdata1), .BWritedata(bwdata1),
        .AAck(aack1), .BAck(back1), .AErr(aerr1), .BErr(berr1),
        .AReaddata(ardata1), .BReaddata(brdata1),
        .Address(address1), .Writedata(writedata1),
        .MemRead(memread1), .MemWrite(memwrite1),
        .Readdata(readdata1), .Busy(busy1)
    );

    datamem_arbiter #(.DEPTH(65), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .AReq(areq3), .BReq(breq3), .AWrite(awrite3), .BWrite(bwrite3),
        .AAddress(aaddr3), .BAddress(baddr3),
        .AWritedata(awdata3), .BWritedata(bwdata3),
        .AAck(aack3), .BAck(back3), .AErr(aerr3), .BErr(berr3),
        .AReaddata(ardata3), .BReaddata(brdata3),
        .Address(address3), .Writedata(writedata3),
        .MemRead(memread3), .MemWrite(memwrite3),
        .Readdata(readdata3), .Busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: preloaded words until written, Readdata zero unless MemRead.
    function automatic logic [31:0] init_word(input logic [6:0] a);
        case (a)
            7'd1:    return 32'd32;
            7'd2:    return 32'd40;
            7'd3:    return 32'd47;
            7'd64:   return 32'd123;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0]  mem1 [0:127];
    logic [127:0] wr1 = '0;
    logic [31:0]  mem3 [0:127];
    logic [127:0] wr3 = '0;

    always @(posedge clk) begin
        if (memwrite1) begin
            mem1[address1[6:0]] <= writedata1;
            wr1[address1[6:0]]  <= 1'b1;
        end
        if (memwrite3) begin
            mem3[address3[6:0]] <= writedata3;
            wr3[address3[6:0]]  <= 1'b1;
        end
    end

    assign readdata1 = !memread1 ? 32'd0 :
                       (wr1[address1[6:0]] ? mem1[address1[6:0]] : init_word(address1[6:0]));
    assign readdata3 = !memread3 ? 32'd0 :
                       (wr3[address3[6:0]] ? mem3[address3[6:0]] : init_word(address3[6:0]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        areq1 = 1'b1; awrite1 = 1'b0; aaddr1 = 32'd1;
        breq1 = 1'b1; bwrite1 = 1'b0; baddr1 = 32'd2;
        tick; tick;
        checks++; if ({aack1, back1, aerr1, berr1, memread1, memwrite1, busy1} !== 7'd0) begin
            errors++; $display("FAIL reset_flags1: got %b want 0000000", {aack1, back1, aerr1, berr1, memread1, memwrite1, busy1}); end
        checks++; if ({address1, writedata1, ardata1, brdata1} !== 128'd0) begin
            errors++; $display("FAIL reset_data1: got %h want 0", {address1, writedata1, ardata1, brdata1}); end
        checks++; if ({aack3, back3, memread3, memwrite3, busy3, address3, ardata3} !== 69'd0) begin
            errors++; $display("FAIL reset_dut3: got %h want 0", {aack3, back3, memread3, memwrite3, busy3, address3, ardata3}); end
        reset = 1'b0;
        tick;
        checks++; if ({memread1, busy1, address1} !== {1'b1, 1'b1, 32'd1}) begin
            errors++; $display("FAIL reset_first_grant: got %h want %h", {memread1, busy1, address1}, {1'b1, 1'b1, 32'd1}); end
        tick;
        checks++; if ({aack1, back1, ardata1} !== {2'b10, 32'd32}) begin
            errors++; $display("FAIL reset_a_ack: got %h want %h", {aack1, back1, ardata1}, {2'b10, 32'd32}); end
        areq1 = 1'b0;
        tick; tick;
        checks++; if ({memread1, address1} !== {1'b1, 32'd2}) begin
            errors++; $display("FAIL reset_b_serve: got %h want %h", {memread1, address1}, {1'b1, 32'd2}); end
        tick;
        checks++; if ({aack1, back1, brdata1} !== {2'b01, 32'd40}) begin
            errors++; $display("FAIL reset_b_ack: got %h want %h", {aack1, back1, brdata1}, {2'b01, 32'd40}); end
        breq1 = 1'b0;
        tick;
    endtask

    task automatic test_single_read;
        areq1 = 1'b1; awrite1 = 1'b0; aaddr1 = 32'd3;
        tick;
        checks++; if ({memread1, memwrite1, aack1} !== 3'b100) begin
            errors++; $display("FAIL single_c1: got %b want 100", {memread1, memwrite1, aack1}); end
        tick;
        checks++; if ({memread1, aack1, aerr1, back1} !== 4'b0100) begin
            errors++; $display("FAIL single_c2: got %b want 0100", {memread1, aack1, aerr1, back1}); end
        checks++; if (ardata1 !== 32'd47) begin
            errors++; $display("FAIL single_data: got %0d want 47", ardata1); end
        areq1 = 1'b0;
        tick;
        checks++; if ({busy1, aack1, back1, ardata1} !== {3'b000, 32'd47}) begin
            errors++; $display("FAIL single_c3: got %h want %h", {busy1, aack1, back1, ardata1}, {3'b000, 32'd47}); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] bad [2];
        bad[0] = 32'd65;
        bad[1] = 32'h8000_0003;
        foreach (bad[i]) begin
            areq1 = 1'b1; awrite1 = 1'b0; aaddr1 = bad[i];
            tick;
            checks++; if ({aack1, aerr1, memread1, memwrite1, address1} !== {4'b1100, 32'd3}) begin
                errors++; $display("FAIL oor_a_%0d: got %h want %h", i, {aack1, aerr1, memread1, memwrite1, address1}, {4'b1100, 32'd3}); end
            areq1 = 1'b0;
            tick;
            checks++; if ({busy1, aack1} !== 2'b00) begin
                errors++; $display("FAIL oor_a_idle_%0d: got %b want 00", i, {busy1, aack1}); end
        end
        areq1 = 1'b1; aaddr1 = 32'd64;
        tick;
        checks++; if ({memread1, address1} !== {1'b1, 32'd64}) begin
            errors++; $display("FAIL edge64_serve: got %h want %h", {memread1, address1}, {1'b1, 32'd64}); end
        tick;
        checks++; if ({aack1, aerr1, ardata1} !== {2'b10, 32'd123}) begin
            errors++; $display("FAIL edge64_ack: got %h want %h", {aack1, aerr1, ardata1}, {2'b10, 32'd123}); end
        areq1 = 1'b0;
        tick;
        breq1 = 1'b1; bwrite1 = 1'b0; baddr1 = 32'd70;
        tick;
        checks++; if ({back1, berr1, memread1, memwrite1, busy1} !== 5'b11001) begin
            errors++; $display("FAIL oor_b_c1: got %b want 11001", {back1, berr1, memread1, memwrite1, busy1}); end
        checks++; if (brdata1 !== 32'd40) begin
            errors++; $display("FAIL oor_b_rdata: got %0d want 40", brdata1); end
        breq1 = 1'b0;
        tick;
        checks++; if ({busy1, back1, memread1} !== 3'b000) begin
            errors++; $display("FAIL oor_b_c2: got %b want 000", {busy1, back1, memread1}); end
    endtask

    task automatic test_simultaneous;
        areq1 = 1'b1; awrite1 = 1'b0; aaddr1 = 32'd2;
        breq1 = 1'b1; bwrite1 = 1'b1; baddr1 = 32'd4; bwdata1 = 32'd99;
        tick;
        checks++; if ({memread1, memwrite1, back1, address1} !== {3'b100, 32'd2}) begin
            errors++; $display("FAIL sim_a_serve: got %h want %h", {memread1, memwrite1, back1, address1}, {3'b100, 32'd2}); end
        tick;
        checks++; if ({aack1, back1, ardata1} !== {2'b10, 32'd40}) begin
            errors++; $display("FAIL sim_a_ack: got %h want %h", {aack1, back1, ardata1}, {2'b10, 32'd40}); end
        areq1 = 1'b0;
        tick;
        checks++; if ({busy1, memwrite1} !== 2'b00) begin
            errors++; $display("FAIL sim_gap: got %b want 00", {busy1, memwrite1}); end
        tick;
        checks++; if ({memwrite1, memread1, address1, writedata1} !== {2'b10, 32'd4, 32'd99}) begin
            errors++; $display("FAIL sim_b_write: got %h want %h", {memwrite1, memread1, address1, writedata1}, {2'b10, 32'd4, 32'd99}); end
        tick;
        checks++; if ({back1, berr1, aack1, memwrite1, brdata1} !== {4'b1000, 32'd40}) begin
            errors++; $display("FAIL sim_b_ack: got %h want %h", {back1, berr1, aack1, memwrite1, brdata1}, {4'b1000, 32'd40}); end
        breq1 = 1'b0;
        tick;
        checks++; if ({wr1[4], mem1[4]} !== {1'b1, 32'd99}) begin
            errors++; $display("FAIL sim_mem4: got %h want %h", {wr1[4], mem1[4]}, {1'b1, 32'd99}); end
    endtask

    task automatic test_back_to_back;
        // An A-only access makes A the last grant, so B must win the tie.
        areq1 = 1'b1; awrite1 = 1'b0; aaddr1 = 32'd3;
        tick; tick;
        checks++; if ({aack1, ardata1} !== {1'b1, 32'd47}) begin
            errors++; $display("FAIL b2b_a_only: got %h want %h", {aack1, ardata1}, {1'b1, 32'd47}); end
        areq1 = 1'b0;
        tick;
        areq1 = 1'b1; aaddr1 = 32'd2;
        breq1 = 1'b1; bwrite1 = 1'b0; baddr1 = 32'd4;
        tick;
        checks++; if ({memread1, address1} !== {1'b1, 32'd4}) begin
            errors++; $display("FAIL b2b_b_first: got %h want %h", {memread1, address1}, {1'b1, 32'd4}); end
        tick;
        checks++; if ({back1, aack1, brdata1} !== {2'b10, 32'd99}) begin
            errors++; $display("FAIL b2b_b_ack: got %h want %h", {back1, aack1, brdata1}, {2'b10, 32'd99}); end
        breq1 = 1'b0;
        tick; tick;
        checks++; if ({memread1, address1} !== {1'b1, 32'd2}) begin
            errors++; $display("FAIL b2b_a_serve: got %h want %h", {memread1, address1}, {1'b1, 32'd2}); end
        tick;
        checks++; if ({aack1, back1, ardata1} !== {2'b10, 32'd40}) begin
            errors++; $display("FAIL b2b_a_ack: got %h want %h", {aack1, back1, ardata1}, {2'b10, 32'd40}); end
        areq1 = 1'b0;
        tick;
    endtask

    task automatic test_lat3_write;
        areq3 = 1'b1; awrite3 = 1'b1; aaddr3 = 32'd5; awdata3 = 32'd7;
        for (int c = 1; c <= 3; c++) begin
            tick;
            checks++; if ({memwrite3, memread3, busy3, aack3} !== 4'b1010) begin
                errors++; $display("FAIL lat3_c%0d: got %b want 1010", c, {memwrite3, memread3, busy3, aack3}); end
        end
        tick;
        checks++; if ({memwrite3, busy3, aack3, aerr3} !== 4'b0110) begin
            errors++; $display("FAIL lat3_ack: got %b want 0110", {memwrite3, busy3, aack3, aerr3}); end
        areq3 = 1'b0;
        tick;
        checks++; if ({busy3, aack3, ardata3} !== {2'b00, 32'd0}) begin
            errors++; $display("FAIL lat3_idle: got %h want 0", {busy3, aack3, ardata3}); end
        checks++; if ({wr3[5], mem3[5]} !== {1'b1, 32'd7}) begin
            errors++; $display("FAIL lat3_mem5: got %h want %h", {wr3[5], mem3[5]}, {1'b1, 32'd7}); end
    endtask

    task automatic test_reset_mid;
        int seen;
        areq3 = 1'b1; awrite3 = 1'b0; aaddr3 = 32'd1;
        tick; tick;
        checks++; if (memread3 !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got %b want 1", memread3); end
        reset = 1'b1;
        tick;
        checks++; if ({memread3, busy3, aack3, address3} !== {3'b000, 32'd0}) begin
            errors++; $display("FAIL mid_reset: got %h want 0", {memread3, busy3, aack3, address3}); end
        reset = 1'b0; areq3 = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (aack3 || busy3) seen++;
        end
        checks++; if (seen !== 0) begin
            errors++; $display("FAIL mid_no_ack: got %0d active cycles want 0", seen); end
        areq3 = 1'b1; aaddr3 = 32'd1;
        tick; tick; tick;
        checks++; if ({memread3, address3} !== {1'b1, 32'd1}) begin
            errors++; $display("FAIL mid_fresh_serve: got %h want %h", {memread3, address3}, {1'b1, 32'd1}); end
        tick;
        checks++; if ({aack3, ardata3} !== {1'b1, 32'd32}) begin
            errors++; $display("FAIL mid_fresh_ack: got %h want %h", {aack3, ardata3}, {1'b1, 32'd32}); end
        areq3 = 1'b0;
        tick;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        areq1 = 1'b0; breq1 = 1'b0; awrite1 = 1'b0; bwrite1 = 1'b0;
        aaddr1 = 32'd0; baddr1 = 32'd0; awdata1 = 32'd0; bwdata1 = 32'd0;
        areq3 = 1'b0; breq3 = 1'b0; awrite3 = 1'b0; bwrite3 = 1'b0;
        aaddr3 = 32'd0; baddr3 = 32'd0; awdata3 = 32'd0; bwdata3 = 32'd0;
        test_reset;
        test_single_read;
        test_out_of_range;
        test_simultaneous;
        test_back_to_back;
        test_lat3_write;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
